// File: rtl/arb_rr8_ctrl.sv
// arb_rr8_ctrl: 8-way round-robin arbiter. A grant is held for as long as the
// holder keeps requesting. When the holder releases, the pointer moves past it
// and the next requester is granted on the same edge, with no idle cycle.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a holder is
// forced to release after HOLD_MAX cycles if another requester is waiting,
// and preempt pulses for one cycle.
module arb_rr8_ctrl #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    generate
        if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
            $error("arb_rr8_ctrl: HOLD_MAX must be in 2..255");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic [7:0] gnt_q, gnt_d;

    logic [7:0] others;
    logic [2:0] search_ptr;
    logic [7:0] search_vec;
    logic       win_found;
    logic [2:0] win_idx;
    logic       holder_req;
    logic       release_now;
    logic       timeout_hit;
    logic       new_grant;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       pre_q, pre_d;
`endif

    // Arbitration: pick the first requester in search order from the pointer.
    // In IDLE the stored pointer is used; in GRANT the search starts one past
    // the holder and excludes it (it is either releasing or being preempted).
    always_comb begin
        holder_req  = req[idx_q];
        others      = req & ~(8'b1 << idx_q);
        search_ptr  = (state_q == IDLE) ? ptr_q : idx_q + 3'd1;
        search_vec  = (state_q == IDLE) ? req : others;
        win_found   = 1'b0;
        win_idx     = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!win_found && search_vec[search_ptr + 3'(i)]) begin
                win_found = 1'b1;
                win_idx   = search_ptr + 3'(i);
            end
        end
        release_now = (state_q == GRANT) && !holder_req;
`ifdef ARB_TIMEOUT_EN
        timeout_hit = (state_q == GRANT) && holder_req
                      && (cnt_q == 8'(HOLD_MAX - 1));
`else
        timeout_hit = 1'b0;
`endif
        new_grant   = win_found
                      && ((state_q == IDLE) || release_now || timeout_hit);
    end

    // Next-state logic: FSM state, round-robin pointer and hold counter.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE:  if (win_found) state_d = GRANT;
            GRANT: if (release_now && !win_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Pointer advances past the holder on voluntary or forced release only.
        if (release_now || (timeout_hit && win_found)) begin
            ptr_d = idx_q + 3'd1;
        end
`ifdef ARB_TIMEOUT_EN
        if (new_grant || timeout_hit || state_d == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
`endif
    end

    // Output logic: next values of the registered grant outputs.
    always_comb begin
        vld_d = (state_d == GRANT);
        if (new_grant) begin
            idx_d = win_idx;
        end else if (state_d == GRANT) begin
            idx_d = idx_q;
        end else begin
            idx_d = '0;
        end
        gnt_d = vld_d ? (8'b1 << idx_d) : '0;
`ifdef ARB_TIMEOUT_EN
        pre_d = timeout_hit && win_found;
`endif
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            gnt_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            pre_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            gnt_q   <= gnt_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
`ifdef ARB_TIMEOUT_EN
    assign preempt = pre_q;
`else
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_arb_rr8_ctrl.sv
// Directed testbench for arb_rr8_ctrl: a table of per-cycle vectors followed
// by hand-written multi-cycle sequences (timeout behaviour depends on whether
// ARB_TIMEOUT_EN is defined).
module tb_arb_rr8_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       preempt;

    int checks   = 0;
    int failures = 0;

    arb_rr8_ctrl #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       pre;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic [7:0] rq);
        @(negedge clk);
        rst_n = r;
        req   = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] eg, input logic [2:0] ei,
                         input logic ev, input logic ep);
        checks++;
        if (gnt !== eg || gnt_idx !== ei || gnt_vld !== ev || preempt !== ep) begin
            failures++;
            $display("FAIL %s: got gnt=%h idx=%0d vld=%b pre=%b, expected gnt=%h idx=%0d vld=%b pre=%b",
                     nm, gnt, gnt_idx, gnt_vld, preempt, eg, ei, ev, ep);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;

        //            rst   req    gnt    idx  vld   pre
        tbl[0]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // reset
        tbl[1]  = '{1'b0, 8'h81, 8'h00, 3'd0, 1'b0, 1'b0}; // reset beats req
        tbl[2]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // idle x5
        tbl[3]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0}; // ptr 0 -> req0
        tbl[8]  = '{1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0}; // no-bubble handoff
        tbl[9]  = '{1'b1, 8'h83, 8'h80, 3'd7, 1'b1, 1'b0}; // others ignored
        tbl[10] = '{1'b1, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0}; // ptr wraps 7->0
        tbl[11] = '{1'b1, 8'h02, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // release to idle
        tbl[13] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 8'h0C, 8'h04, 3'd2, 1'b1, 1'b0}; // ptr 2
        tbl[15] = '{1'b0, 8'h04, 8'h00, 3'd0, 1'b0, 1'b0}; // mid-grant reset
        tbl[16] = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 8'h05, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0}; // ptr 3 wraps to 0
        tbl[19] = '{1'b1, 8'h41, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // ptr now 7
        tbl[22] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0}; // reset clears ptr
        tbl[23] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 8'h82, 8'h02, 3'd1, 1'b1, 1'b0}; // search from 0
        tbl[25] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].rst_n, tbl[i].req);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].pre);
        end

        // Constant contention between requesters 1 and 2.
        step(1'b0, 8'h00);
        for (int k = 1; k <= 21; k++) begin
            step(1'b1, 8'h06);
`ifdef ARB_TIMEOUT_EN
            if (k <= 9) begin
                if (k <= 4 || k == 9) begin
                    check($sformatf("timeout_c%0d", k), 8'h02, 3'd1, 1'b1, (k == 9));
                end else begin
                    check($sformatf("timeout_c%0d", k), 8'h04, 3'd2, 1'b1, (k == 5));
                end
            end
`else
            check($sformatf("hold_c%0d", k), 8'h02, 3'd1, 1'b1, 1'b0);
`endif
        end

        // Lone requester held far beyond HOLD_MAX keeps the grant.
        step(1'b0, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 8'h08);
            check($sformatf("lone_c%0d", k), 8'h08, 3'd3, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
